seq_addsub_slice: RTL and testbench

//   Multi-cycle WIDTH-bit adder/subtractor built around one SLICE-bit carry-lookahead slice.

---
 rtl/seq_addsub_slice_if.sv | 26 ++
 rtl/seq_addsub_slice.sv | 141 ++++++++++++++
 tb/tb_seq_addsub_slice.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_slice_if.sv
// Handshake bundle for seq_addsub_slice.
// The producer/consumer side uses master. The arithmetic block uses slave.
interface seq_addsub_slice_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, c_out, overflow
  );
endinterface

// File: rtl/seq_addsub_slice.sv
// Multi-cycle adder/subtractor.
// A single SLICE-bit carry-lookahead slice is reused once per cycle, starting with the LSB slice.
// The carry/borrow is registered between slices.
// Subtraction is a + ~b + 1: b is inverted when it is latched, and the carry starts at 1.
module seq_addsub_slice #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_addsub_slice_if.slave  bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_cOut;
  logic             r_overflow;
  logic [KW-1:0]    r_k;
  logic [SLICE-1:0] w_sliceA;
  logic [SLICE-1:0] w_sliceB;
  logic [SLICE-1:0] w_sliceSum;
  logic [SLICE:0]   w_carries;
  logic             w_lastSlice;
  logic             w_accept;
  logic             w_inReady;
  logic             w_outValid;

  assign w_lastSlice   = (r_k == KW'(N - 1));
  assign w_accept      = (r_state == IDLE) && bus.in_valid;
  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.result    = r_result;
  assign bus.c_out     = r_cOut;
  assign bus.overflow  = r_overflow;

  // Pick the operand slice addressed by the slice counter
  always_comb begin
    w_sliceA = '0;
    w_sliceB = '0;
    for (int s = 0; s < N; s++) begin
      if (r_k == KW'(s)) begin
        w_sliceA = r_opA[s*SLICE +: SLICE];
        w_sliceB = r_opB[s*SLICE +: SLICE];
      end
    end
  end

  // Carry-lookahead slice.
  // Each carry is built directly from the generate/propagate terms and the incoming carry.
  always_comb begin
    logic [SLICE-1:0] w_prop;
    logic [SLICE-1:0] w_gen;
    logic             w_term;
    logic             w_chain;
    w_prop    = w_sliceA ^ w_sliceB;
    w_gen     = w_sliceA & w_sliceB;
    w_carries = '0;
    w_carries[0] = r_carry;
    for (int i = 0; i < SLICE; i++) begin
      w_term  = w_gen[i];
      w_chain = w_prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_term  = w_term | (w_chain & w_gen[j]);
        w_chain = w_chain & w_prop[j];
      end
      w_term = w_term | (w_chain & r_carry);
      w_carries[i+1] = w_term;
    end
    w_sliceSum = w_prop ^ w_carries[SLICE-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs.
  // The block accepts operands only in IDLE and presents a result only in DONE.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) w_nextState = BUSY;
      end
      BUSY: begin
        if (w_lastSlice) w_nextState = DONE;
      end
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture and slice-by-slice accumulation.
  // Result and flags are left untouched outside BUSY, so they hold after handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opA      <= '0;
      r_opB      <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_cOut     <= 1'b0;
      r_overflow <= 1'b0;
      r_k        <= '0;
    end else if (w_accept) begin
      r_opA   <= bus.a;
      r_opB   <= bus.b ^ {WIDTH{bus.sub}};
      r_carry <= bus.sub;
      r_k     <= '0;
    end else if (r_state == BUSY) begin
      for (int s = 0; s < N; s++) begin
        if (r_k == KW'(s)) r_result[s*SLICE +: SLICE] <= w_sliceSum;
      end
      r_carry <= w_carries[SLICE];
      if (w_lastSlice) begin
        r_k        <= '0;
        r_cOut     <= w_carries[SLICE];
        r_overflow <= w_carries[SLICE] ^ w_carries[SLICE-1];
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end
endmodule

// File: tb/tb_seq_addsub_slice.sv
// Directed and randomized checks for seq_addsub_slice at WIDTH=16, SLICE=4.
module tb_seq_addsub_slice;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;

  seq_addsub_slice_if #(.WIDTH(WIDTH)) bus ();

  seq_addsub_slice #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock with a 10 ns period
  always #5 clk = ~clk;

  task automatic sendOp(input logic [15:0] a, input logic [15:0] b, input logic s);
    int cyc = 0;
    @(negedge clk);
    while (!bus.in_ready && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    nChecks++;
    if (cyc >= 60) begin
      nFails++;
      $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, cyc);
    end
    bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic waitResult();
    int cyc = 0;
    @(negedge clk);
    while (!bus.out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    nChecks++;
    if (cyc >= 60) begin
      nFails++;
      $display("[TB] FAIL result_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, cyc);
    end
  endtask

  task automatic takeResult();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nChecks++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.c_out, bus.overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b res=%h c=%b ov=%b, required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.c_out, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    sendOp(16'h1234, 16'h4321, 1'b0);
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      #1;
      nChecks++;
      if (bus.out_valid !== (i == N)) begin
        nFails++;
        $display("[TB] FAIL latency_edge%0d: out_valid=%b, required %b", i, bus.out_valid, (i == N));
      end
    end
    nChecks++;
    if ({bus.result, bus.c_out, bus.overflow, bus.in_ready} !== {16'h5555, 1'b0, 1'b0, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL add_basic: got res=%h c=%b ov=%b rdy=%b, required 5555 0 0 0",
               bus.result, bus.c_out, bus.overflow, bus.in_ready);
    end
    takeResult();
    nChecks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      nFails++;
      $display("[TB] FAIL after_handoff: rdy=%b vld=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    nChecks++;
    if (bus.result !== 16'h5555) begin
      nFails++;
      $display("[TB] FAIL result_hold: res=%h, required 5555", bus.result);
    end
  endtask

  task automatic test_carry_ripple();
    sendOp(16'hFFFF, 16'h0001, 1'b0);
    waitResult();
    nChecks++;
    if ({bus.result, bus.c_out, bus.overflow} !== {16'h0000, 1'b1, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL carry_ripple: got res=%h c=%b ov=%b, required 0000 1 0", bus.result, bus.c_out, bus.overflow);
    end
    takeResult();
  endtask

  task automatic test_subtract();
    sendOp(16'h0003, 16'h0005, 1'b1);
    waitResult();
    nChecks++;
    if ({bus.result, bus.c_out, bus.overflow} !== {16'hFFFE, 1'b0, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL sub_borrow: got res=%h c=%b ov=%b, required FFFE 0 0", bus.result, bus.c_out, bus.overflow);
    end
    takeResult();
    sendOp(16'h8000, 16'h0001, 1'b1);
    waitResult();
    nChecks++;
    if ({bus.result, bus.c_out, bus.overflow} !== {16'h7FFF, 1'b1, 1'b1}) begin
      nFails++;
      $display("[TB] FAIL sub_overflow: got res=%h c=%b ov=%b, required 7FFF 1 1", bus.result, bus.c_out, bus.overflow);
    end
    takeResult();
  endtask

  task automatic test_stall();
    sendOp(16'h00FF, 16'h0001, 1'b0);
    waitResult();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.sub      = 1'($urandom);
      @(negedge clk);
      nChecks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.c_out, bus.overflow} !== {1'b1, 1'b0, 16'h0100, 1'b0, 1'b0}) begin
        nFails++;
        $display("[TB] FAIL stall_hold%0d: got vld=%b rdy=%b res=%h c=%b ov=%b, required 1 0 0100 0 0",
                 i, bus.out_valid, bus.in_ready, bus.result, bus.c_out, bus.overflow);
      end
    end
    bus.in_valid = 1'b0;
    takeResult();
    @(negedge clk);
    nChecks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      nFails++;
      $display("[TB] FAIL stall_release: rdy=%b vld=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    sendOp(16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    nChecks++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.c_out, bus.overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL reset_mid: got rdy=%b vld=%b res=%h c=%b ov=%b, required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.c_out, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    nChecks++;
    if (bus.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_abort: out_valid=%b, required 0", bus.out_valid);
    end
    sendOp(16'h0001, 16'h0001, 1'b0);
    waitResult();
    nChecks++;
    if ({bus.result, bus.c_out, bus.overflow} !== {16'h0002, 1'b0, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL post_reset_op: got res=%h c=%b ov=%b, required 0002 0 0", bus.result, bus.c_out, bus.overflow);
    end
    takeResult();
  endtask

  task automatic test_random();
    logic [17:0] expQ[$];
    int          received = 0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          logic [15:0] ra, rb, bb;
          logic        rs;
          logic [16:0] sum;
          logic        ov;
          ra  = 16'($urandom);
          rb  = 16'($urandom);
          rs  = 1'($urandom);
          bb  = rs ? ~rb : rb;
          sum = {1'b0, ra} + {1'b0, bb} + {16'h0000, rs};
          ov  = (ra[15] == bb[15]) && (sum[15] != ra[15]);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          sendOp(ra, rb, rs);
          expQ.push_back({sum, ov});
        end
      end
      begin
        int cyc = 0;
        while (received < 200 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          bus.out_ready = 1'($urandom);
          if (bus.out_valid && bus.out_ready) begin
            logic [17:0] exp;
            exp = (expQ.size() > 0) ? expQ.pop_front() : 18'h3FFFF;
            nChecks++;
            if ({bus.c_out, bus.result, bus.overflow} !== exp) begin
              nFails++;
              $display("[TB] FAIL random_op%0d: got c=%b res=%h ov=%b, required c=%b res=%h ov=%b",
                       received, bus.c_out, bus.result, bus.overflow, exp[17], exp[16:1], exp[0]);
            end
            received++;
          end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    nChecks++;
    if (received != 200 || expQ.size() != 0 || bus.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL random_count: received=%0d pending=%0d vld=%b, required 200 0 0",
               received, expQ.size(), bus.out_valid);
    end
  endtask

  // Run every scenario in order, then print the summary
  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    test_reset();
    test_add();
    test_carry_ripple();
    test_subtract();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
